// File: rtl/pc_ctrl.sv
// Next-PC sequencer for the fetch stage: arbitrates trap/branch/jump redirects,
// parks redirects that arrive during a stall, emits flush pulses, handles halt and captures epc.
module pc_ctrl #(
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  input  logic        halt,
  input  logic        resume,
  input  logic [31:0] pc_q,
  output logic        pc_en,
  output logic        pc_load_en,
  output logic [31:0] pc_d,
  output logic        flush,
  output logic [31:0] epc,
  output logic [1:0]  state
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2,
    PEND  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   pend_tgt_r, pend_tgt_s;
  logic          pend_valid_r, pend_valid_s;
  logic [31:0]   epc_r, epc_s;

  logic          redir_s;
  logic [31:0]   redir_tgt_s;
  logic          issue_s;
  logic [31:0]   issue_tgt_s;
  logic          park_s;
  logic [31:0]   park_tgt_s;

  assign redir_s     = trap | br_taken | jmp_valid;
  assign redir_tgt_s = trap ? TRAP_VEC : (br_taken ? br_target : jmp_target);
  assign state       = state_r;
  assign epc         = epc_r;

  // Next-state and Mealy outputs; issue/park requests are resolved after the state case.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pend_tgt_s   = pend_tgt_r;
    pend_valid_s = pend_valid_r;
    epc_s        = epc_r;
    pc_en        = 1'b0;
    pc_load_en   = 1'b0;
    pc_d         = 32'd0;
    flush        = 1'b0;
    issue_s      = 1'b0;
    issue_tgt_s  = 32'd0;
    park_s       = 1'b0;
    park_tgt_s   = 32'd0;

    case (state_r)
      RUN: begin
        if (redir_s) begin
          epc_s       = trap ? pc_q : epc_r;
          issue_s     = !stall;
          park_s      = stall;
          issue_tgt_s = redir_tgt_s;
          park_tgt_s  = redir_tgt_s;
        end else if (halt) begin
          state_s = HALT;
        end else begin
          pc_en = !stall;
        end
      end
      PEND: begin
        // A trap replaces whatever redirect is parked; branch/jump are dropped here.
        if (trap) begin
          epc_s      = pc_q;
          pend_tgt_s = TRAP_VEC;
        end else begin
          pend_tgt_s = pend_tgt_r;
        end
        if (!stall) begin
          pend_valid_s = 1'b0;
          issue_s      = pend_valid_r;
          issue_tgt_s  = trap ? TRAP_VEC : pend_tgt_r;
          state_s      = RUN;
        end else begin
          pend_valid_s = pend_valid_r;
        end
      end
      FLUSH: begin
        if (trap) begin
          epc_s       = pc_q;
          issue_s     = !stall;
          park_s      = stall;
          issue_tgt_s = TRAP_VEC;
          park_tgt_s  = TRAP_VEC;
        end else begin
          flush = 1'b1;
          pc_en = !stall;
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
          state_s = (cnt_r <= {{(CW-1){1'b0}}, 1'b1}) ? RUN : FLUSH;
        end
      end
      HALT: begin
        if (trap) begin
          epc_s       = pc_q;
          issue_s     = !stall;
          park_s      = stall;
          issue_tgt_s = TRAP_VEC;
          park_tgt_s  = TRAP_VEC;
        end else if (resume) begin
          state_s = RUN;
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase

    if (park_s) begin
      pend_tgt_s   = park_tgt_s;
      pend_valid_s = 1'b1;
      cnt_s        = {CW{1'b0}};
      state_s      = PEND;
    end else begin
      pend_valid_s = pend_valid_s;
    end

    if (issue_s) begin
      pc_en      = 1'b1;
      pc_load_en = 1'b1;
      pc_d       = issue_tgt_s;
      flush      = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_s = RUN;
        cnt_s   = {CW{1'b0}};
      end else begin
        state_s = FLUSH;
        cnt_s   = CNT_RELOAD;
      end
    end else begin
      pc_d = pc_load_en ? pc_d : 32'd0;
    end

    // Reset gates the pc register controls so nothing loads while it is held.
    if (!reset) begin
      pc_en      = 1'b0;
      pc_load_en = 1'b0;
      pc_d       = 32'd0;
      flush      = 1'b0;
    end else begin
      flush = flush;
    end
  end

  // State, flush counter, parked redirect and epc registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= RUN;
      cnt_r        <= {CW{1'b0}};
      pend_tgt_r   <= 32'd0;
      pend_valid_r <= 1'b0;
      epc_r        <= 32'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pend_tgt_r   <= pend_tgt_s;
      pend_valid_r <= pend_valid_s;
      epc_r        <= epc_s;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Table-driven scoreboard bench for pc_ctrl: dut0 uses FLUSH_CYCLES=2, dut1 uses FLUSH_CYCLES=4.
module tb_pc_ctrl;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        trap;
    logic        halt;
    logic        res;
    logic [31:0] pcq;
    logic        en;
    logic        ld;
    logic [31:0] d;
    logic        fl;
    logic [1:0]  st;
    logic [31:0] epc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        stall, br_taken, jmp_valid, trap, halt, resume;
  logic [31:0] br_target, jmp_target, pc_q;
  logic        pc_en0, pc_load_en0, flush0, pc_en1, pc_load_en1, flush1;
  logic [31:0] pc_d0, epc0, pc_d1, epc1;
  logic [1:0]  state0, state1;

  int   n_run = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  pc_ctrl #(.TRAP_VEC(32'h0000_0100), .FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset0), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .trap(trap), .halt(halt), .resume(resume),
    .pc_q(pc_q), .pc_en(pc_en0), .pc_load_en(pc_load_en0), .pc_d(pc_d0), .flush(flush0),
    .epc(epc0), .state(state0)
  );

  pc_ctrl #(.TRAP_VEC(32'h0000_0100), .FLUSH_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset1), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .trap(trap), .halt(halt), .resume(resume),
    .pc_q(pc_q), .pc_en(pc_en1), .pc_load_en(pc_load_en1), .pc_d(pc_d1), .flush(flush1),
    .epc(epc1), .state(state1)
  );

  function automatic vec_t mk(input logic sel, input logic rst, input logic stl,
                              input logic br, input logic [31:0] bt,
                              input logic jmp, input logic [31:0] jt,
                              input logic trp, input logic hlt, input logic res,
                              input logic [31:0] pcq,
                              input logic en, input logic ld, input logic [31:0] d,
                              input logic fl, input logic [1:0] st, input logic [31:0] e);
    vec_t v;
    v.sel = sel; v.rst = rst; v.stall = stl; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.trap = trp; v.halt = hlt; v.res = res; v.pcq = pcq;
    v.en = en; v.ld = ld; v.d = d; v.fl = fl; v.st = st; v.epc = e;
    return v;
  endfunction

  // Drive one cycle of stimulus at the falling edge, queue its expectation, then sample.
  task automatic step(input vec_t v, input int idx);
    vec_t  x;
    logic  a_en, a_ld, a_fl;
    logic [31:0] a_d, a_epc;
    logic [1:0]  a_st;
    @(negedge clk);
    reset0     = v.sel ? 1'b0 : v.rst;
    reset1     = v.sel ? v.rst : 1'b0;
    stall      = v.stall;
    br_taken   = v.br;
    br_target  = v.bt;
    jmp_valid  = v.jmp;
    jmp_target = v.jt;
    trap       = v.trap;
    halt       = v.halt;
    resume     = v.res;
    pc_q       = v.pcq;
    sb.push_back(v);
    #2;
    x     = sb.pop_front();
    a_en  = x.sel ? pc_en1 : pc_en0;
    a_ld  = x.sel ? pc_load_en1 : pc_load_en0;
    a_d   = x.sel ? pc_d1 : pc_d0;
    a_fl  = x.sel ? flush1 : flush0;
    a_st  = x.sel ? state1 : state0;
    a_epc = x.sel ? epc1 : epc0;
    n_run++;
    if (a_en !== x.en || a_ld !== x.ld || a_d !== x.d || a_fl !== x.fl ||
        a_st !== x.st || a_epc !== x.epc) begin
      n_fail++;
      $display("FAIL dut%0d step %0d: got en=%b ld=%b d=%h fl=%b st=%0d epc=%h, want en=%b ld=%b d=%h fl=%b st=%0d epc=%h",
               x.sel, idx, a_en, a_ld, a_d, a_fl, a_st, a_epc,
               x.en, x.ld, x.d, x.fl, x.st, x.epc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b0; reset1 = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
    trap = 1'b0; halt = 1'b0; resume = 1'b0;
    br_target = 32'd0; jmp_target = 32'd0; pc_q = 32'd0;
    @(posedge clk);

    //             sel  rst  stl  br   bt         jmp  jt         trp  hlt  res  pcq          en   ld   d          fl   st     epc
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0));
    // branch, two flush cycles
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,32'h40,   1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b1,32'h40,   1'b1,2'd0,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b1,2'd1,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0));
    // jump during stall is parked until stall drops
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b1,32'h80,   1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd3,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd3,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b1,32'h80,   1'b1,2'd3,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b1,2'd1,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0));
    // trap beats branch, epc captured
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,32'h40,   1'b0,32'h0,    1'b1,1'b0,1'b0,32'h1C,    1'b1,1'b1,32'h100,  1'b1,2'd0,32'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b1,2'd1,32'h1C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h1C));
    // halt, hold, resume
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b1,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h1C));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd2,32'h1C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b1,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd2,32'h1C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h1C));
    // halt then trap out of HALT
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b1,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h1C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b1,1'b0,1'b1,32'h2A0,   1'b1,1'b1,32'h100,  1'b1,2'd2,32'h1C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b1,2'd1,32'h2A0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h2A0));
    // trap restarts FLUSH; branch inside FLUSH ignored
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,32'h40,   1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b1,32'h40,   1'b1,2'd0,32'h2A0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b1,1'b0,1'b0,32'h33C,   1'b1,1'b1,32'h100,  1'b1,2'd1,32'h2A0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,32'h44,   1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b1,2'd1,32'h33C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h33C));
    // stall inside FLUSH: counter still runs down
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b1,32'h80,   1'b0,1'b0,1'b0,32'h0,     1'b1,1'b1,32'h80,   1'b1,2'd0,32'h33C));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b1,2'd1,32'h33C));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h33C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h33C));
    // trap overwrites a parked branch
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1,32'h40,   1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h33C));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b0,32'h0,    1'b1,1'b0,1'b0,32'h500,   1'b0,1'b0,32'h0,    1'b0,2'd3,32'h33C));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b1,32'h100,  1'b1,2'd3,32'h500));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b1,2'd1,32'h500));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h500));
    // reset while PEND discards the parked jump
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,    1'b1,32'h80,   1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd0,32'h500));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b0,1'b0,32'h0,    1'b0,2'd3,32'h500));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h0,    1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,     1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // FLUSH_CYCLES=4: reset in the middle of FLUSH, then a full four-cycle flush.
    step(mk(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,  1'b0,2'd0,32'h0), 100);
    step(mk(1'b1,1'b1,1'b0,1'b1,32'h40, 1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,32'h40, 1'b1,2'd0,32'h0), 101);
    step(mk(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,  1'b1,2'd1,32'h0), 102);
    step(mk(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,  1'b0,2'd1,32'h0), 103);
    step(mk(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,  1'b0,2'd0,32'h0), 104);
    step(mk(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h60,1'b0,1'b0,1'b0,32'h0,1'b1,1'b1,32'h60, 1'b1,2'd0,32'h0), 105);
    for (int i = 0; i < 3; i++)
      step(mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,  1'b1,2'd1,32'h0), 106 + i);
    step(mk(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,  1'b0,2'd0,32'h0), 109);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
